pc_redirect_unit: RTL and testbench

Fetch-side PC generator that consumes the taken-branch decision (PCSrc) and the EX-stage branch target, and steers instruction fetch accordingly. It owns the PC register, issues requests to instruction memory with a ready handshake, and honours hazard stalls. On a taken branch it flushes the IF/ID and ID/EX registers, then holds fetch until memory accepts the new target. It also keeps a saturating taken-branch counter for performance visibility.

---
 rtl/pc_redirect_unit_pkg.sv | 17 +
 rtl/pc_redirect_unit_sat_counter.sv | 21 ++
 rtl/pc_redirect_unit.sv | 114 +++++++++++
 tb/tb_pc_redirect_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the fetch-side PC redirect unit:
// state encodings, instruction size and default reset parameters.
package pc_redirect_unit_pkg;

   // Default datapath width and boot address used when the top is not overridden
   localparam int          DEFAULT_XLEN         = 32;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   // Every instruction occupies one 32-bit word, so sequential fetch steps by 4
   localparam int          INSTR_BYTES          = 4;

   // Fetch FSM encoding, kept as plain constants so older blocks can share them
   localparam logic [1:0]  ST_BOOT              = 2'd0;
   localparam logic [1:0]  ST_FETCH             = 2'd1;
   localparam logic [1:0]  ST_REDIRECT          = 2'd2;

endpackage : pc_redirect_unit_pkg

// File: rtl/pc_redirect_unit_sat_counter.sv
// Saturating up-counter. Increments on INC and sticks at all-ones so a
// long-running performance counter never wraps back to a misleading small value.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         INC,
   output logic [W-1:0] CNT
);

   // Count up on INC until every bit is set, then hold
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         CNT <= '0;
      end else if (INC && !(&CNT)) begin
         CNT <= CNT + W'(1);
      end
   end

endmodule : sat_counter

// File: rtl/pc_redirect_unit.sv
// Fetch-side PC generator. Owns the PC, issues fetch requests to instruction
// memory, honours hazard stalls and steers fetch to a new target when the EX
// stage reports a taken branch. Taken redirects are counted for performance
// visibility and misaligned targets raise a one-cycle MISALIGN pulse.
module pc_redirect_unit
   import pc_redirect_unit_pkg::*;
#(
   parameter int              XLEN         = DEFAULT_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
   parameter int              CNT_W        = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             PCSRC,
   input  logic [XLEN-1:0]  BRANCH_TARGET,
   input  logic             STALL,
   input  logic             IMEM_READY,
   output logic             IMEM_REQ,
   output logic [XLEN-1:0]  IMEM_ADDR,
   output logic [XLEN-1:0]  PC_PLUS4,
   output logic             IF_VALID,
   output logic             FLUSH,
   output logic             MISALIGN,
   output logic [CNT_W-1:0] BR_TAKEN_CNT
);

   logic [1:0]      state_q;
   logic [1:0]      state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic            misalign_d;
   logic            active;
   logic            take_redirect;
   logic [XLEN-1:0] aligned_target;

   // A redirect is only honoured once fetch is running; during BOOT the
   // branch input belongs to nothing we have fetched and is ignored.
   always_comb begin
      active         = (state_q == ST_FETCH) || (state_q == ST_REDIRECT);
      take_redirect  = active && PCSRC;
      aligned_target = {BRANCH_TARGET[XLEN-1:2], 2'b00};
   end

   // Fetch-side outputs. The address is always the PC; a word is only
   // handed to IF/ID in FETCH when memory answers, nothing stalls it and no
   // older branch is about to squash it. FLUSH covers both the branch cycle
   // itself and every cycle spent waiting for the target to be accepted.
   always_comb begin
      IMEM_REQ  = (state_q != ST_BOOT);
      IMEM_ADDR = pc_q;
      PC_PLUS4  = pc_q + XLEN'(INSTR_BYTES);
      IF_VALID  = (state_q == ST_FETCH) && IMEM_READY && !STALL && !PCSRC;
      FLUSH     = (state_q == ST_REDIRECT) || take_redirect;
   end

   // Next-state and next-PC selection. A taken branch outranks a stall
   // because the stalled instruction is younger than the branch and is
   // being squashed anyway. Leaving REDIRECT does not advance the PC: the
   // target word is presented again in FETCH and delivered from there.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      misalign_d = 1'b0;
      if (take_redirect) begin
         state_d    = ST_REDIRECT;
         pc_d       = aligned_target;
         misalign_d = |BRANCH_TARGET[1:0];
      end else begin
         case (state_q)
            ST_BOOT: begin
               state_d = ST_FETCH;
            end
            ST_FETCH: begin
               if (IF_VALID) begin
                  pc_d = PC_PLUS4;
               end
            end
            ST_REDIRECT: begin
               if (IMEM_READY) begin
                  state_d = ST_FETCH;
               end
            end
            default: begin
               state_d = ST_BOOT;
               pc_d    = RESET_VECTOR;
            end
         endcase
      end
   end

   // State, PC and the misalignment pulse register. Reset drops any pending
   // target and restarts fetch from the boot address.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_VECTOR;
         MISALIGN <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         MISALIGN <= misalign_d;
      end
   end

   sat_counter #(
      .W   (CNT_W)
   ) u_br_taken_cnt (
      .CLK (CLK),
      .RST (RST),
      .INC (take_redirect),
      .CNT (BR_TAKEN_CNT)
   );

endmodule : pc_redirect_unit

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: a table of per-cycle vectors with expected
// outputs, plus hand-written saturation and reset sequences. Expectations
// are queued when a cycle is driven and compared once outputs settle.
module tb_pc_redirect_unit;

   logic        CLK;
   logic        RST;
   logic        PCSRC;
   logic [31:0] BRANCH_TARGET;
   logic        STALL;
   logic        IMEM_READY;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic [31:0] PC_PLUS4;
   logic        IF_VALID;
   logic        FLUSH;
   logic        MISALIGN;
   logic [3:0]  BR_TAKEN_CNT;

   typedef struct {
      logic        rst;
      logic        pcsrc;
      logic [31:0] tgt;
      logic        stall;
      logic        ready;
      logic        req;
      logic [31:0] addr;
      logic        ifv;
      logic        flush;
      logic        mis;
      logic [3:0]  cnt;
   } vec_t;

   typedef struct {
      int          idx;
      logic        req;
      logic [31:0] addr;
      logic        ifv;
      logic        flush;
      logic        mis;
      logic [3:0]  cnt;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   checks;
   int   errors;

   pc_redirect_unit #(
      .XLEN          (32),
      .RESET_VECTOR  (32'h0000_0000),
      .CNT_W         (4)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .PCSRC         (PCSRC),
      .BRANCH_TARGET (BRANCH_TARGET),
      .STALL         (STALL),
      .IMEM_READY    (IMEM_READY),
      .IMEM_REQ      (IMEM_REQ),
      .IMEM_ADDR     (IMEM_ADDR),
      .PC_PLUS4      (PC_PLUS4),
      .IF_VALID      (IF_VALID),
      .FLUSH         (FLUSH),
      .MISALIGN      (MISALIGN),
      .BR_TAKEN_CNT  (BR_TAKEN_CNT)
   );

   // 10-unit clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic addVec(input logic rst, input logic pcsrc, input logic [31:0] tgt,
                         input logic stall, input logic ready, input logic req,
                         input logic [31:0] addr, input logic ifv, input logic flush,
                         input logic mis, input logic [3:0] cnt);
      vec_t v;
      v.rst = rst; v.pcsrc = pcsrc; v.tgt = tgt; v.stall = stall; v.ready = ready;
      v.req = req; v.addr = addr; v.ifv = ifv; v.flush = flush; v.mis = mis; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic chk(input int idx, input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL step%0d %s: got 0x%0h expected 0x%0h", idx, name, act, expv);
      end
   endtask

   // Drive one cycle of inputs away from the rising edge and queue its expectation
   task automatic applyStimulus(input int idx, input vec_t v);
      exp_t e;
      @(negedge CLK);
      RST           = v.rst;
      PCSRC         = v.pcsrc;
      BRANCH_TARGET = v.tgt;
      STALL         = v.stall;
      IMEM_READY    = v.ready;
      e.idx = idx; e.req = v.req; e.addr = v.addr; e.ifv = v.ifv;
      e.flush = v.flush; e.mis = v.mis; e.cnt = v.cnt;
      exp_q.push_back(e);
   endtask

   // Let combinational outputs settle, then compare against the oldest expectation
   task automatic checkOutput();
      exp_t e;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard: got empty queue expected an entry");
         return;
      end
      checks--;
      e = exp_q.pop_front();
      chk(e.idx, "imem_req",  {31'b0, IMEM_REQ},     {31'b0, e.req});
      chk(e.idx, "imem_addr", IMEM_ADDR,             e.addr);
      chk(e.idx, "pc_plus4",  PC_PLUS4,              e.addr + 32'd4);
      chk(e.idx, "if_valid",  {31'b0, IF_VALID},     {31'b0, e.ifv});
      chk(e.idx, "flush",     {31'b0, FLUSH},        {31'b0, e.flush});
      chk(e.idx, "misalign",  {31'b0, MISALIGN},     {31'b0, e.mis});
      chk(e.idx, "br_cnt",    {28'b0, BR_TAKEN_CNT}, {28'b0, e.cnt});
   endtask

   // Table, then saturation sequence, then reset clearing the counter
   initial begin
      vec_t v;
      int   step;
      checks = 0;
      errors = 0;
      RST = 1'b1; PCSRC = 1'b0; BRANCH_TARGET = '0; STALL = 1'b0; IMEM_READY = 1'b0;

      //     rst pcs tgt            stl rdy | req addr           ifv fl  mis cnt
      addVec(1, 1, 32'h0000_0040, 0, 1,     0, 32'h0000_0000, 0, 0, 0, 4'd0); // reset
      addVec(0, 0, 32'h0,         0, 1,     0, 32'h0000_0000, 0, 0, 0, 4'd0); // boot
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0000, 1, 0, 0, 4'd0);
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0004, 1, 0, 0, 4'd0);
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0008, 1, 0, 0, 4'd0);
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_000C, 1, 0, 0, 4'd0);
      addVec(0, 0, 32'h0,         1, 1,     1, 32'h0000_0010, 0, 0, 0, 4'd0); // stall x3
      addVec(0, 0, 32'h0,         1, 1,     1, 32'h0000_0010, 0, 0, 0, 4'd0);
      addVec(0, 0, 32'h0,         1, 1,     1, 32'h0000_0010, 0, 0, 0, 4'd0);
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0010, 1, 0, 0, 4'd0);
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0014, 1, 0, 0, 4'd0);
      addVec(0, 1, 32'h0000_0200, 0, 1,     1, 32'h0000_0018, 0, 1, 0, 4'd0); // branch N
      addVec(0, 0, 32'h0,         0, 0,     1, 32'h0000_0200, 0, 1, 0, 4'd1);
      addVec(0, 0, 32'h0,         0, 0,     1, 32'h0000_0200, 0, 1, 0, 4'd1);
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0200, 0, 1, 0, 4'd1);
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0200, 1, 0, 0, 4'd1);
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0204, 1, 0, 0, 4'd1);
      addVec(0, 1, 32'h0000_0080, 1, 1,     1, 32'h0000_0208, 0, 1, 0, 4'd1); // pcsrc+stall
      addVec(0, 1, 32'h0000_0090, 0, 0,     1, 32'h0000_0080, 0, 1, 0, 4'd2); // back-to-back
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0090, 0, 1, 0, 4'd3);
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0090, 1, 0, 0, 4'd3);
      addVec(0, 1, 32'h0000_0102, 0, 1,     1, 32'h0000_0094, 0, 1, 0, 4'd3); // misaligned
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0100, 0, 1, 1, 4'd4);
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0100, 1, 0, 0, 4'd4);
      addVec(0, 1, 32'hFFFF_FFFC, 0, 1,     1, 32'h0000_0104, 0, 1, 0, 4'd4); // wrap target
      addVec(0, 0, 32'h0,         0, 1,     1, 32'hFFFF_FFFC, 0, 1, 0, 4'd5);
      addVec(0, 0, 32'h0,         0, 1,     1, 32'hFFFF_FFFC, 1, 0, 0, 4'd5);
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0000, 1, 0, 0, 4'd5);
      addVec(0, 0, 32'h0,         0, 0,     1, 32'h0000_0004, 0, 0, 0, 4'd5); // not ready
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0004, 1, 0, 0, 4'd5);
      addVec(0, 1, 32'h0000_0300, 0, 1,     1, 32'h0000_0008, 0, 1, 0, 4'd5);
      addVec(0, 0, 32'h0,         0, 0,     1, 32'h0000_0300, 0, 1, 0, 4'd6);
      addVec(1, 0, 32'h0,         0, 0,     0, 32'h0000_0000, 0, 0, 0, 4'd0); // reset mid-redirect
      addVec(0, 1, 32'h0000_0400, 0, 1,     0, 32'h0000_0000, 0, 0, 0, 4'd0); // boot ignores pcsrc
      addVec(0, 0, 32'h0,         0, 1,     1, 32'h0000_0000, 1, 0, 0, 4'd0);

      step = 0;
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(step, vecs[i]);
         checkOutput();
         step++;
      end

      // Twenty back-to-back taken branches; the 4-bit counter must pin at 15
      for (int i = 0; i < 20; i++) begin
         v.rst = 0; v.pcsrc = 1; v.tgt = 32'h0000_0040; v.stall = 0; v.ready = 1;
         v.req = 1; v.addr = (i == 0) ? 32'h0000_0004 : 32'h0000_0040;
         v.ifv = 0; v.flush = 1; v.mis = 0;
         v.cnt = (i > 15) ? 4'hF : 4'(i);
         applyStimulus(step, v);
         checkOutput();
         step++;
      end

      v.rst = 0; v.pcsrc = 0; v.tgt = '0; v.stall = 0; v.ready = 1;
      v.req = 1; v.addr = 32'h0000_0040; v.ifv = 0; v.flush = 1; v.mis = 0; v.cnt = 4'hF;
      applyStimulus(step, v); checkOutput(); step++;

      v.ifv = 1; v.flush = 0;
      applyStimulus(step, v); checkOutput(); step++;

      v.rst = 1; v.req = 0; v.addr = 32'h0000_0000; v.ifv = 0; v.cnt = 4'h0;
      applyStimulus(step, v); checkOutput(); step++;

      v.rst = 0;
      applyStimulus(step, v); checkOutput(); step++;

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pc_redirect_unit
